// File: rtl/stopwatch_lap.sv
`default_nettype none
// ============================================================================
// Module   : stopwatch_lap
// Brief    : MM:SS.CC up/down stopwatch with three debounced keys, a lap
//            FIFO with recall, and active-low 7-segment outputs.
// Revision : 1.0
// ============================================================================
module stopwatch_lap #(
    parameter int CLK_DIV    = 500000,
    parameter int DELAY_TIME = 5000000,
    parameter int LAP_DEPTH  = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_start_pause,
    input  logic       key_lap,
    input  logic       key_clear,
    input  logic       mode_down,
    input  logic [7:0] preset_min,
    output logic [6:0] hex0,
    output logic [6:0] hex1,
    output logic [6:0] hex2,
    output logic [6:0] hex3,
    output logic [6:0] hex4,
    output logic [6:0] hex5,
    output logic       led_run,
    output logic       led_done,
    output logic       led_full,
    output logic       led_recall,
    output logic [4:0] lap_count
);

    localparam int DBW = (DELAY_TIME > 2) ? $clog2(DELAY_TIME) : 1;
    localparam int DVW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int PTW = (LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1;

    localparam logic [DBW-1:0] c_db_last  = DBW'(DELAY_TIME - 1);
    localparam logic [DVW-1:0] c_div_last = DVW'(CLK_DIV - 1);
    localparam logic [PTW-1:0] c_ptr_last = PTW'(LAP_DEPTH - 1);
    localparam logic [4:0]     c_depth    = 5'(LAP_DEPTH);
    localparam logic [23:0]    c_time_max = 24'h995999;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [2:0]     w_key;
    logic [2:0]     w_pulse;
    logic           w_ev_clr;
    logic           w_ev_start;
    logic           w_ev_lap;
    logic           w_tick;
    logic           w_full;
    logic           w_push;
    logic           w_carry;
    logic           w_borrow;
    logic [23:0]    w_inc;
    logic [23:0]    w_dec;
    logic [23:0]    w_preset;
    logic [23:0]    w_disp;
    logic [23:0]    r_time;
    logic [23:0]    r_recall_time;
    logic [23:0]    r_mem [LAP_DEPTH];
    logic [DVW-1:0] r_div;
    logic [PTW-1:0] r_wr;
    logic [PTW-1:0] r_rd;
    logic [4:0]     r_cnt;
    logic           r_down;
    logic           r_recall;

    function automatic logic [PTW-1:0] ptr_next(input logic [PTW-1:0] p);
        return (p == c_ptr_last) ? '0 : p + PTW'(1);
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    assign w_key = {key_clear, key_lap, key_start_pause};

    // Armed: count consecutive lows to accept; disarmed: count consecutive highs to rearm.
    for (genvar g = 0; g < 3; g++) begin : g_debounce
        logic           r_armed;
        logic           r_fire;
        logic [DBW-1:0] r_dcnt;

        always_ff @(posedge clk) begin
            if (reset) begin
                r_armed <= 1'b1;
                r_fire  <= 1'b0;
                r_dcnt  <= '0;
            end else begin
                r_fire <= 1'b0;
                if (r_armed == w_key[g]) begin
                    r_dcnt <= '0;
                end else if (r_dcnt == c_db_last) begin
                    r_dcnt  <= '0;
                    r_armed <= ~r_armed;
                    r_fire  <= r_armed;
                end else begin
                    r_dcnt <= r_dcnt + DBW'(1);
                end
            end
        end

        assign w_pulse[g] = r_fire;
    end

    assign w_ev_clr   = w_pulse[2];
    assign w_ev_start = w_pulse[0] & ~w_pulse[2];
    assign w_ev_lap   = w_pulse[1] & ~w_pulse[0] & ~w_pulse[2];

    assign w_tick   = (r_state == S_RUN) && (r_div == c_div_last);
    assign w_full   = (r_cnt == c_depth);
    assign w_push   = w_ev_lap && (r_state == S_RUN) && !w_full;
    assign w_preset = {(preset_min[7:4] > 4'd9) ? 4'd9 : preset_min[7:4],
                       (preset_min[3:0] > 4'd9) ? 4'd9 : preset_min[3:0],
                       16'h0000};

    // BCD ripple increment/decrement over the six digits, wrapping at 99:59.99.
    always_comb begin
        w_inc    = r_time;
        w_dec    = r_time;
        w_carry  = 1'b1;
        w_borrow = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (w_carry) begin
                if (r_time[4*i +: 4] >= c_time_max[4*i +: 4]) begin
                    w_inc[4*i +: 4] = 4'd0;
                end else begin
                    w_inc[4*i +: 4] = r_time[4*i +: 4] + 4'd1;
                    w_carry         = 1'b0;
                end
            end
            if (w_borrow) begin
                if (r_time[4*i +: 4] == 4'd0) begin
                    w_dec[4*i +: 4] = c_time_max[4*i +: 4];
                end else begin
                    w_dec[4*i +: 4] = r_time[4*i +: 4] - 4'd1;
                    w_borrow        = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_ev_start) begin
                    w_state_nxt = (mode_down && (w_preset == '0)) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (w_tick && r_down && (w_dec == '0)) begin
                    w_state_nxt = S_DONE;
                end else if (w_ev_start) begin
                    w_state_nxt = S_PAUSE;
                end
            end
            S_PAUSE: begin
                if (w_ev_clr) begin
                    w_state_nxt = S_IDLE;
                end else if (w_ev_start) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_DONE: begin
                if (w_ev_clr) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_time        <= '0;
            r_div         <= '0;
            r_down        <= 1'b0;
            r_recall      <= 1'b0;
            r_recall_time <= '0;
            r_wr          <= '0;
            r_rd          <= '0;
            r_cnt         <= '0;
        end else begin
            if (r_state == S_RUN) begin
                if (w_tick) begin
                    r_div  <= '0;
                    r_time <= r_down ? w_dec : w_inc;
                end else begin
                    r_div <= r_div + DVW'(1);
                end
            end
            if (w_ev_clr) begin
                if (r_state != S_RUN) begin
                    r_time   <= '0;
                    r_div    <= '0;
                    r_wr     <= '0;
                    r_rd     <= '0;
                    r_cnt    <= '0;
                    r_recall <= 1'b0;
                end
            end else if (w_ev_start) begin
                r_recall <= 1'b0;
                if (r_state == S_IDLE) begin
                    r_div  <= '0;
                    r_down <= mode_down;
                    r_time <= mode_down ? w_preset : '0;
                end
            end else if (w_ev_lap) begin
                if (r_state == S_RUN) begin
                    if (w_push) begin
                        r_wr  <= ptr_next(r_wr);
                        r_cnt <= r_cnt + 5'd1;
                    end
                end else if (r_cnt != 5'd0) begin
                    r_recall_time <= r_mem[r_rd];
                    r_rd          <= ptr_next(r_rd);
                    r_cnt         <= r_cnt - 5'd1;
                    r_recall      <= 1'b1;
                end else begin
                    r_recall <= 1'b0;
                end
            end
        end
    end

    // Lap storage needs no reset; entries are only read while r_cnt covers them.
    always_ff @(posedge clk) begin
        if (w_push && !reset) begin
            r_mem[r_wr] <= r_time;
        end
    end

    assign w_disp = r_recall ? r_recall_time : r_time;

    assign hex0       = seg7(w_disp[3:0]);
    assign hex1       = seg7(w_disp[7:4]);
    assign hex2       = seg7(w_disp[11:8]);
    assign hex3       = seg7(w_disp[15:12]);
    assign hex4       = seg7(w_disp[19:16]);
    assign hex5       = seg7(w_disp[23:20]);
    assign led_run    = (r_state == S_RUN);
    assign led_done   = (r_state == S_DONE);
    assign led_full   = w_full;
    assign led_recall = r_recall;
    assign lap_count  = r_cnt;

endmodule
`default_nettype wire

// File: doc/stopwatch_lap.md
STOPWATCH_LAP -- requirements
Module: stopwatch_lap

Interface
REQ-001 Parameter CLK_DIV, default 500000, clk cycles per 0.01 s tick (>=2).
REQ-002 Parameter DELAY_TIME, default 5000000, debounce length in clk cycles (>=2).
REQ-003 Parameter LAP_DEPTH, default 8, lap memory entries (1..16).
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 key_start_pause  in  1  active-low push button, start/pause.
REQ-007 key_lap  in  1  active-low push button, lap store / lap recall.
REQ-008 key_clear  in  1  active-low push button, clear.
REQ-009 mode_down  in  1  1 = countdown, 0 = count up; sampled only on start from IDLE.
REQ-010 preset_min  in  8  BCD countdown start minutes {tens, units}; a digit >9 is taken as 9.
REQ-011 hex0..hex5  out  7 each  active-low segments for cs-low, cs-high, s-low, s-high, min-low, min-high; 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-012 led_run  out  1  high in RUN.
REQ-013 led_done  out  1  high in DONE.
REQ-014 led_full  out  1  high while lap memory holds LAP_DEPTH entries.
REQ-015 led_recall  out  1  high while a recalled lap is displayed.
REQ-016 lap_count  out  5  number of stored laps, 0..LAP_DEPTH.

Function
REQ-017 Each key has its own debouncer; a press is accepted after DELAY_TIME consecutive low cycles and yields one single-cycle internal pulse.
REQ-018 After an accepted press, a key rearms only after DELAY_TIME consecutive high cycles; any bounce restarts the relevant count.
REQ-019 Time is held as six BCD digits MM:SS.CC; seconds-high counts 0..5, all other digits 0..9.
REQ-020 States IDLE, RUN, PAUSE, DONE; reset state IDLE.
REQ-021 IDLE + start: up mode -> time 00:00.00, RUN; down mode -> time preset:00.00, RUN; down mode with preset 00 -> DONE immediately.
REQ-022 RUN + start -> PAUSE; PAUSE + start -> RUN; DONE + start ignored.
REQ-023 Tick divider advances only in RUN, is retained through PAUSE, and is zeroed on start from IDLE, clear and reset.
REQ-024 A tick occurs on the cycle the divider equals CLK_DIV-1; the divider then returns to 0, and the time changes by one centisecond, visible on the next cycle.
REQ-025 Up mode: 99:59.99 + 1 tick -> 00:00.00, with counting continuing.
REQ-026 Down mode: the tick that reaches 00:00.00 enters DONE; the display holds 00:00.00.
REQ-027 RUN + lap: the current time is pushed to the lap FIFO; if the FIFO is full, the push is dropped and the contents are unchanged.
REQ-028 PAUSE/IDLE/DONE + lap with lap_count>0: the oldest entry is popped and shown, and led_recall goes to 1; with lap_count=0, the live time is shown and led_recall goes to 0.
REQ-029 Display source is live time unless led_recall=1; led_recall clears on start, clear or reset.
REQ-030 Clear in IDLE/PAUSE/DONE: time 00:00.00, FIFO flushed, led_recall 0, -> IDLE; clear in RUN is ignored.
REQ-031 Simultaneous accepted pulses are handled by priority clear > start_pause > lap; a lower-priority pulse in the same cycle is discarded.
REQ-032 A lap push coinciding with a tick stores the pre-tick time.
REQ-033 mode_down and preset_min changes outside IDLE have no effect.
REQ-034 Segment outputs are combinational decodes of the displayed digits; any non-BCD code is shown blank (1111111).

Reset
REQ-035 Reset, including mid-RUN and mid-debounce, forces: IDLE; time 00:00.00; divider 0; FIFO empty; debouncers cleared and armed.
REQ-036 After reset: hex0..hex5 = 1000000; led_run, led_done, led_full, led_recall = 0; lap_count = 0.
REQ-037 Reset takes priority over every key pulse in the same cycle.

Verification (CLK_DIV=4, DELAY_TIME=3, LAP_DEPTH=2)
REQ-038 Up mode: hold start low for 3 cycles, then run 4000 cycles -> display 00:10.00 and led_run=1; press start again -> PAUSE with the display frozen.
REQ-039 Start low for 2 cycles, high for 1 cycle, then low for 2 cycles -> no accepted press and the state stays IDLE.
REQ-040 In RUN, press lap 3 times at 00:00.05, 00:00.10 and 00:00.15 -> lap_count=2 and led_full=1; pause, then press lap -> 00:00.05 shown; press lap -> 00:00.10; press lap -> live time shown with led_recall=0.
REQ-041 Down mode with preset_min=8'h01: start, then 60000 cycles -> display 00:00.00, led_done=1, led_run=0; press clear -> IDLE.
REQ-042 Force time to 99:59.99 in up mode and apply 1 tick -> 00:00.00 with led_run still 1.
REQ-043 Press clear and start in the same cycle while in PAUSE -> IDLE with 00:00.00; assert reset mid-RUN -> all outputs at REQ-036 values on the next cycle.
